mdu_unit: RTL and testbench
===========================

Name: mdu_unit

Overview:
- Parametrised multiply/divide unit; successor to the single-cycle combinational ALU.
- Sits beside the ALU in the EX stage and owns the HI/LO register pair.
- Executes multi-cycle signed/unsigned multiply and divide operations with a busy handshake. The pipeline stalls on `busy`.
- Also serves single-cycle HI/LO writes.

Parameters:
- WIDTH, 32, operand and HI/LO width in bits (≥2).
- MUL_CYCLES, 5, busy cycles for multiply ops (≥1).
- DIV_CYCLES, 10, busy cycles for divide ops (≥1).

Ports:
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  op request, sampled on rising edge
- op  in  4  operation code (encoding below)
- A  in  WIDTH  operand A / dividend / MTHI-MTLO source
- B  in  WIDTH  operand B / divisor
- busy  out  1  multi-cycle op in flight
- done  out  1  one-cycle pulse: HI/LO just committed by a multi-cycle op
- hi  out  WIDTH  HI register
- lo  out  WIDTH  LO register

Behaviour:
- Interface: one clock `clk`. Reset `reset_n` is asynchronous and active-low.
- Reset: while reset_n=0, hi=0, lo=0, busy=0, done=0, FSM=IDLE, counter=0. Reset asserted mid-operation aborts the op; no partial commit.
- Op encoding:
  - 0000 MULT
  - 0001 MULTU
  - 0010 DIV
  - 0011 DIVU
  - 0100 MTHI
  - 0101 MTLO
  - 0110 MADD (optional)
  - 0111 MADDU (optional)
  - All other codes are no-ops: no state change, no busy.
- FSM states: IDLE, BUSY.
- IDLE, start=1, multiply op (edge T0):
  - Latch A and B; load counter with MUL_CYCLES.
  - Go to BUSY; busy=1 from the cycle after T0.
- IDLE, start=1, divide op: same as multiply, with counter = DIV_CYCLES.
- IDLE, start=1, MTHI/MTLO:
  - hi<=A (MTHI) or lo<=A (MTLO) at T0.
  - No busy, no done. Visible the next cycle.
- BUSY: counter decrements each edge. On the edge where the counter reaches 0:
  - Commit hi/lo; go to IDLE; busy<=0, done<=1 for exactly one cycle.
- Latency: busy is high for exactly MUL_CYCLES or DIV_CYCLES cycles. New hi/lo are visible in the same cycle done=1.
- Old hi/lo remain readable, unchanged, throughout BUSY.
- start while busy=1 is ignored entirely, including MTHI/MTLO. The issuer must stall.
- start in the done cycle (busy=0) is accepted normally, giving back-to-back ops.
- Operands are sampled only at T0; changes to A/B during BUSY have no effect.
- Multiply arithmetic:
  - Full 2*WIDTH-bit product; {hi,lo} = product.
  - MULT treats A and B as two's complement; MULTU treats them as unsigned.
- Divide arithmetic:
  - lo = quotient, hi = remainder.
  - DIV truncates toward zero; the remainder takes the sign of the dividend.
  - DIVU is unsigned.
- Divide boundary cases:
  - Divide by zero (B=0, DIV or DIVU): lo = all ones, hi = A. The operation still takes DIV_CYCLES cycles.
  - Signed overflow (A = most-negative value, B = -1, DIV): lo = A, hi = 0.
- Result computation may be combinational on the latched operands. Only the commit timing is architected.

Optional Feature:
- Macro: MDU_MADD_EN.
- Defined:
  - op 0110 MADD: {hi,lo} <= {hi,lo} + signed(A*B), with 2*WIDTH-bit wrap-around.
  - op 0111 MADDU: same, with an unsigned product.
  - Both take MUL_CYCLES cycles.
  - The accumulator base {hi,lo} is sampled at commit, not at T0.
- Undefined: 0110 and 0111 are no-ops like other unused codes. No accumulate datapath is synthesised.

Test Plan:
- Reset then MULT: A=0xFFFFFFFE (-2), B=3 -> busy high 5 cycles; done pulse; hi=0xFFFFFFFF, lo=0xFFFFFFFA.
- MULTU with A=0xFFFFFFFF, B=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001 after 5 busy cycles.
- DIV: A=-7 (0xFFFFFFF9), B=2 -> busy 10 cycles; lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1).
- DIVU by zero: A=0x12345678, B=0 -> lo=0xFFFFFFFF, hi=0x12345678. DIV with A=0x80000000, B=0xFFFFFFFF -> lo=0x80000000, hi=0.
- MTHI A=0xAAAA5555 in idle -> hi=0xAAAA5555 next cycle, busy stays 0. MTLO issued during a DIV busy -> ignored, lo only takes the divide result.
- Assert reset_n=0 in the 3rd busy cycle of a MULT -> hi=lo=0, busy=0 immediately. After release, a MULT issued in a done cycle directly following another op completes correctly.

Source files
------------

// File: rtl/mdu_unit_if.sv
// Handshake/bus bundle between the EX-stage issuer and the multiply/divide unit.
// master = issuer (pipeline), slave = mdu_unit.
interface mdu_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [3:0]       op;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, A, B,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, op, A, B,
    output busy, done, hi, lo
  );
endinterface

// File: rtl/mdu_unit.sv
// Multi-cycle multiply/divide unit owning the HI/LO register pair.
// Multiplies hold busy for MUL_CYCLES, divides for DIV_CYCLES; results are
// computed combinationally from the latched operands and committed on the
// last busy edge together with a one-cycle done pulse. MTHI/MTLO write in
// a single cycle from IDLE.
// Optional macro MDU_MADD_EN adds MADD/MADDU (accumulate into {hi,lo});
// without it, codes 0110/0111 are no-ops and no accumulator path exists.
module mdu_unit #(
  parameter int WIDTH      = 32,
  parameter int MUL_CYCLES = 5,
  parameter int DIV_CYCLES = 10
) (
  input  logic      clk,
  input  logic      reset_n,
  mdu_unit_if.slave bus
);

  localparam int CNT_MAX = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [3:0] OP_MULT  = 4'b0000;
  localparam logic [3:0] OP_MULTU = 4'b0001;
  localparam logic [3:0] OP_DIV   = 4'b0010;
  localparam logic [3:0] OP_DIVU  = 4'b0011;
  localparam logic [3:0] OP_MTHI  = 4'b0100;
  localparam logic [3:0] OP_MTLO  = 4'b0101;
`ifdef MDU_MADD_EN
  localparam logic [3:0] OP_MADD  = 4'b0110;
  localparam logic [3:0] OP_MADDU = 4'b0111;
`endif

  typedef enum logic [0:0] {IDLE, BUSY} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               done_q, done_d;
  logic               latch_en;
  logic [WIDTH-1:0]   a_q, b_q;
  logic [3:0]         op_q;
  logic [2*WIDTH-1:0] result;

  // Full 2*WIDTH product; sign- or zero-extension picks MULT vs MULTU.
  function automatic logic [2*WIDTH-1:0] mul_full(input logic [WIDTH-1:0] a,
                                                  input logic [WIDTH-1:0] b,
                                                  input logic             sgn);
    logic signed [2*WIDTH-1:0] ax;
    logic signed [2*WIDTH-1:0] bx;
    logic signed [2*WIDTH-1:0] p;
    ax = sgn ? $signed({{WIDTH{a[WIDTH-1]}}, a}) : $signed({{WIDTH{1'b0}}, a});
    bx = sgn ? $signed({{WIDTH{b[WIDTH-1]}}, b}) : $signed({{WIDTH{1'b0}}, b});
    p  = ax * bx;
    return $unsigned(p);
  endfunction

  // Returns {remainder, quotient}. Signed divide works on magnitudes, then
  // restores signs: quotient truncates toward zero, remainder follows the
  // dividend. Divide-by-zero and MIN/-1 have fixed architected results.
  function automatic logic [2*WIDTH-1:0] div_full(input logic [WIDTH-1:0] a,
                                                  input logic [WIDTH-1:0] b,
                                                  input logic             sgn);
    logic             neg_a;
    logic             neg_b;
    logic [WIDTH-1:0] mag_a;
    logic [WIDTH-1:0] mag_b;
    logic [WIDTH-1:0] q_mag;
    logic [WIDTH-1:0] r_mag;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] r;
    if (b == '0) begin
      return {a, {WIDTH{1'b1}}};
    end
    if (sgn && (a == {1'b1, {(WIDTH-1){1'b0}}}) && (b == {WIDTH{1'b1}})) begin
      return {{WIDTH{1'b0}}, a};
    end
    neg_a = sgn & a[WIDTH-1];
    neg_b = sgn & b[WIDTH-1];
    mag_a = neg_a ? -a : a;
    mag_b = neg_b ? -b : b;
    q_mag = mag_a / mag_b;
    r_mag = mag_a % mag_b;
    q     = (neg_a ^ neg_b) ? -q_mag : q_mag;
    r     = neg_a ? -r_mag : r_mag;
    return {r, q};
  endfunction

  // Result selection from the operands latched at issue; accumulate base is live {hi,lo}.
  always_comb begin
    result = '0;
    case (op_q)
      OP_MULT:  result = mul_full(a_q, b_q, 1'b1);
      OP_MULTU: result = mul_full(a_q, b_q, 1'b0);
      OP_DIV:   result = div_full(a_q, b_q, 1'b1);
      OP_DIVU:  result = div_full(a_q, b_q, 1'b0);
`ifdef MDU_MADD_EN
      OP_MADD:  result = {hi_q, lo_q} + mul_full(a_q, b_q, 1'b1);
      OP_MADDU: result = {hi_q, lo_q} + mul_full(a_q, b_q, 1'b0);
`endif
      default:  result = '0;
    endcase
  end

  // Next-state logic: accept ops in IDLE, count down in BUSY, commit on the last edge.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;
    latch_en = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          case (bus.op)
            OP_MULT, OP_MULTU: begin
              latch_en = 1'b1;
              cnt_d    = CNT_W'(MUL_CYCLES);
              state_d  = BUSY;
            end
`ifdef MDU_MADD_EN
            OP_MADD, OP_MADDU: begin
              latch_en = 1'b1;
              cnt_d    = CNT_W'(MUL_CYCLES);
              state_d  = BUSY;
            end
`endif
            OP_DIV, OP_DIVU: begin
              latch_en = 1'b1;
              cnt_d    = CNT_W'(DIV_CYCLES);
              state_d  = BUSY;
            end
            OP_MTHI: hi_d = bus.A;
            OP_MTLO: lo_d = bus.A;
            default: ;
          endcase
        end
      end
      BUSY: begin
        if (cnt_q == CNT_W'(1)) begin
          state_d      = IDLE;
          cnt_d        = '0;
          done_d       = 1'b1;
          {hi_d, lo_d} = result;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control and architected HI/LO state; reset aborts any op in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
    end
  end

  // Operand capture at issue only; later changes on A/B are ignored.
  always_ff @(posedge clk) begin
    if (latch_en) begin
      a_q  <= bus.A;
      b_q  <= bus.B;
      op_q <= bus.op;
    end
  end

  assign bus.busy = (state_q == BUSY);
  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

endmodule

// File: tb/tb_mdu_unit.sv
// Scoreboard bench for mdu_unit: stimulus pushes expected {hi,lo,busy length}
// when a multi-cycle op is issued; a forked monitor pops and compares on done.
module tb_mdu_unit;

  localparam int WIDTH = 32;

  localparam logic [3:0] OP_MULT  = 4'b0000;
  localparam logic [3:0] OP_MULTU = 4'b0001;
  localparam logic [3:0] OP_DIV   = 4'b0010;
  localparam logic [3:0] OP_DIVU  = 4'b0011;
  localparam logic [3:0] OP_MTHI  = 4'b0100;
  localparam logic [3:0] OP_MTLO  = 4'b0101;
  localparam logic [3:0] OP_MADD  = 4'b0110;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  mdu_unit_if #(.WIDTH(WIDTH)) bus();

  mdu_unit #(
    .WIDTH(WIDTH),
    .MUL_CYCLES(5),
    .DIV_CYCLES(10)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push(input logic [31:0] hi, input logic [31:0] lo, input int cyc);
    exp_t e;
    e.hi = hi;
    e.lo = lo;
    e.cyc = cyc;
    sb.push_back(e);
  endtask

  task automatic monitor();
    int   run = 0;
    logic prev_done = 1'b0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        run = 0;
        prev_done = 1'b0;
      end else begin
        if (prev_done) chk("done_pulse_width", 32'(bus.done), 32'd0);
        if (bus.busy) begin
          run++;
        end else begin
          if (bus.done) begin
            chk("sb_has_entry", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
              e = sb.pop_front();
              chk("hi", bus.hi, e.hi);
              chk("lo", bus.lo, e.lo);
              chk("busy_len", 32'(run), 32'(e.cyc));
            end
          end
          run = 0;
        end
        prev_done = bus.done;
      end
    end
  endtask

  // Drive an op from the current negedge; returns at the following negedge.
  task automatic issue_now(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
    bus.start = 1'b1;
    bus.op    = o;
    bus.A     = a;
    bus.B     = b;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic issue(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    issue_now(o, a, b);
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (!bus.done && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_done_seen"}, 32'(bus.done), 32'd1);
  endtask

  initial begin
    bus.start = 1'b0;
    bus.op    = 4'b0000;
    bus.A     = '0;
    bus.B     = '0;
    fork
      monitor();
    join_none

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_hi", bus.hi, 32'h0);
    chk("rst_lo", bus.lo, 32'h0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    reset_n = 1'b1;

    // Multiplies
    push(32'hFFFFFFFF, 32'hFFFFFFFA, 5);
    issue(OP_MULT, 32'hFFFFFFFE, 32'd3);
    chk("mult_busy_c1", 32'(bus.busy), 32'd1);
    wait_done("mult");

    push(32'hFFFFFFFE, 32'h00000001, 5);
    issue(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
    wait_done("multu");

    // Divides and boundary cases
    push(32'hFFFFFFFF, 32'hFFFFFFFD, 10);
    issue(OP_DIV, 32'hFFFFFFF9, 32'd2);
    wait_done("div_neg_dividend");

    push(32'h00000001, 32'hFFFFFFFD, 10);
    issue(OP_DIV, 32'd7, 32'hFFFFFFFE);
    wait_done("div_neg_divisor");

    push(32'h12345678, 32'hFFFFFFFF, 10);
    issue(OP_DIVU, 32'h12345678, 32'h0);
    wait_done("divu_by_zero");

    push(32'h00000000, 32'h80000000, 10);
    issue(OP_DIV, 32'h80000000, 32'hFFFFFFFF);
    wait_done("div_overflow");

    // Single-cycle HI/LO writes
    issue(OP_MTHI, 32'hAAAA5555, 32'h0);
    chk("mthi_hi", bus.hi, 32'hAAAA5555);
    chk("mthi_busy", 32'(bus.busy), 32'd0);
    chk("mthi_done", 32'(bus.done), 32'd0);
    issue(OP_MTLO, 32'h13579BDF, 32'h0);
    chk("mtlo_lo", bus.lo, 32'h13579BDF);
    chk("mtlo_hi_kept", bus.hi, 32'hAAAA5555);

    // DIVU with MTLO attempted and operands changed while busy
    push(32'h00000002, 32'h0000000E, 10);
    issue(OP_DIVU, 32'd100, 32'd7);
    chk("busy_old_hi", bus.hi, 32'hAAAA5555);
    chk("busy_old_lo", bus.lo, 32'h13579BDF);
    issue_now(OP_MTLO, 32'hDEADBEEF, 32'h0);
    bus.A = 32'hFFFFFFFF;
    bus.B = 32'h00000001;
    chk("busy_mtlo_ignored", bus.lo, 32'h13579BDF);
    wait_done("divu_busy_ignore");

`ifdef MDU_MADD_EN
    issue(OP_MTHI, 32'h0, 32'h0);
    issue(OP_MTLO, 32'hFFFFFFFF, 32'h0);
    push(32'h00000001, 32'h00000000, 5);
    issue(OP_MADD, 32'd1, 32'd1);
    wait_done("madd");
`else
    // Unused codes: no busy, no state change
    issue(OP_MADD, 32'd5, 32'd5);
    chk("noop6_busy", 32'(bus.busy), 32'd0);
    chk("noop6_hi", bus.hi, 32'h00000002);
    chk("noop6_lo", bus.lo, 32'h0000000E);
    @(negedge clk);
    chk("noop6_done", 32'(bus.done), 32'd0);
`endif
    issue(4'b1111, 32'h11111111, 32'h22222222);
    chk("noopF_busy", 32'(bus.busy), 32'd0);
    @(negedge clk);
    chk("noopF_done", 32'(bus.done), 32'd0);

    // Reset in the 3rd busy cycle of a MULT: abort, no commit
    issue(OP_MULT, 32'd9, 32'd9);
    @(negedge clk);
    @(negedge clk);
    chk("abort_busy_before", 32'(bus.busy), 32'd1);
    reset_n = 1'b0;
    #1;
    chk("abort_hi", bus.hi, 32'h0);
    chk("abort_lo", bus.lo, 32'h0);
    chk("abort_busy", 32'(bus.busy), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (8) @(negedge clk);
    chk("abort_no_commit_lo", bus.lo, 32'h0);

    // Back-to-back: second op issued in the done cycle of the first
    push(32'h00000000, 32'h0000002A, 5);
    push(32'h00000001, 32'h00000000, 5);
    issue(OP_MULT, 32'd7, 32'd6);
    wait_done("b2b_first");
    issue_now(OP_MULTU, 32'h00010000, 32'h00010000);
    chk("b2b_busy", 32'(bus.busy), 32'd1);
    wait_done("b2b_second");

    repeat (3) @(negedge clk);
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
